// File: rtl/phyretrain_sb_arbiter.sv
// Round-robin arbiter sharing the PHYRETRAIN sideband TX channel between the
// TX-side and RX-side message generators, with busy-handshake tracking and a watchdog.
module phyretrain_sb_arbiter #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_tx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
  input  logic [2:0]              i_tx_info,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
  input  logic [2:0]              i_rx_info,
  input  logic                    i_sb_busy,
  output logic                    o_sb_valid,
  output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
  output logic [2:0]              o_sb_info,
  output logic                    o_sb_src,
  output logic                    o_tx_grant,
  output logic                    o_rx_grant,
  output logic                    o_tx_done,
  output logic                    o_rx_done,
  output logic                    o_timeout,
  output logic                    o_falling_edge_busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_dly_q, busy_dly_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sb_valid_q, sb_valid_d;
  logic [SB_MSG_WIDTH-1:0] sb_msg_q, sb_msg_d;
  logic [2:0]              sb_info_q, sb_info_d;
  logic                    sb_src_q, sb_src_d;
  logic                    tx_grant_q, tx_grant_d;
  logic                    rx_grant_q, rx_grant_d;
  logic                    tx_done_q, tx_done_d;
  logic                    rx_done_q, rx_done_d;
  logic                    timeout_q, timeout_d;

  logic falling_edge;
  logic any_req;
  logic pick_rx;
  logic in_transfer;

  assign falling_edge = busy_dly_q & ~i_sb_busy;
  assign any_req      = i_tx_valid | i_rx_valid;
  // On a tie the requester that did not own the channel last time wins.
  assign pick_rx      = i_rx_valid & (~i_tx_valid | ~last_grant_q);
  assign in_transfer  = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

  always_comb begin
    state_d      = state_q;
    busy_dly_d   = i_sb_busy;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sb_valid_d   = sb_valid_q;
    sb_msg_d     = sb_msg_q;
    sb_info_d    = sb_info_q;
    sb_src_d     = sb_src_q;
    tx_grant_d   = tx_grant_q;
    rx_grant_d   = rx_grant_q;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    timeout_d    = 1'b0;

    if (!i_enable) begin
      state_d    = ST_IDLE;
      sb_valid_d = 1'b0;
      tx_grant_d = 1'b0;
      rx_grant_d = 1'b0;
      cnt_d      = '0;
    end else if (state_q == ST_IDLE) begin
      if (any_req) begin
        state_d    = ST_WAIT_BUSY;
        sb_valid_d = 1'b1;
        sb_src_d   = pick_rx;
        sb_msg_d   = pick_rx ? i_rx_msg : i_tx_msg;
        sb_info_d  = pick_rx ? i_rx_info : i_tx_info;
        tx_grant_d = ~pick_rx;
        rx_grant_d = pick_rx;
        cnt_d      = '0;
      end
    end else if (in_transfer) begin
      if (falling_edge || (cnt_q == CNT_LAST)) begin
        // Completion outranks the watchdog when both land in the same cycle.
        state_d      = ST_IDLE;
        sb_valid_d   = 1'b0;
        tx_grant_d   = 1'b0;
        rx_grant_d   = 1'b0;
        last_grant_d = sb_src_q;
        cnt_d        = '0;
        if (falling_edge) begin
          tx_done_d = ~sb_src_q;
          rx_done_d = sb_src_q;
        end else begin
          timeout_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if ((state_q == ST_WAIT_BUSY) && i_sb_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
    end else begin
      state_d    = ST_IDLE;
      sb_valid_d = 1'b0;
      tx_grant_d = 1'b0;
      rx_grant_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      busy_dly_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      sb_valid_q   <= 1'b0;
      sb_msg_q     <= '0;
      sb_info_q    <= '0;
      sb_src_q     <= 1'b0;
      tx_grant_q   <= 1'b0;
      rx_grant_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_dly_q   <= busy_dly_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      sb_valid_q   <= sb_valid_d;
      sb_msg_q     <= sb_msg_d;
      sb_info_q    <= sb_info_d;
      sb_src_q     <= sb_src_d;
      tx_grant_q   <= tx_grant_d;
      rx_grant_q   <= rx_grant_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_sb_valid          = sb_valid_q;
  assign o_sb_msg            = sb_msg_q;
  assign o_sb_info           = sb_info_q;
  assign o_sb_src            = sb_src_q;
  assign o_tx_grant          = tx_grant_q;
  assign o_rx_grant          = rx_grant_q;
  assign o_tx_done           = tx_done_q;
  assign o_rx_done           = rx_done_q;
  assign o_timeout           = timeout_q;
  assign o_falling_edge_busy = falling_edge;

endmodule

// File: tb/tb_phyretrain_sb_arbiter.sv
// Directed table-driven bench for phyretrain_sb_arbiter, plus a hand-written
// watchdog sequence.
module tb_phyretrain_sb_arbiter;

  localparam int W  = 4;
  localparam int TO = 16;

  logic         clk;
  logic         rst, en, txv, rxv, busy;
  logic [W-1:0] txm, rxm;
  logic [2:0]   txi, rxi;
  logic         sb_valid, sb_src, tx_grant, rx_grant, tx_done, rx_done, tmo, fe;
  logic [W-1:0] sb_msg;
  logic [2:0]   sb_info;

  int n_cmp = 0;
  int n_err = 0;

  phyretrain_sb_arbiter #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .i_tx_valid(txv), .i_tx_msg(txm), .i_tx_info(txi),
    .i_rx_valid(rxv), .i_rx_msg(rxm), .i_rx_info(rxi),
    .i_sb_busy(busy),
    .o_sb_valid(sb_valid), .o_sb_msg(sb_msg), .o_sb_info(sb_info), .o_sb_src(sb_src),
    .o_tx_grant(tx_grant), .o_rx_grant(rx_grant),
    .o_tx_done(tx_done), .o_rx_done(rx_done),
    .o_timeout(tmo), .o_falling_edge_busy(fe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed output vector: {valid, msg, info, src, txg, rxg, txd, rxd, timeout}
  typedef struct {
    logic         rst, en, txv;
    logic [W-1:0] txm;
    logic [2:0]   txi;
    logic         rxv;
    logic [W-1:0] rxm;
    logic [2:0]   rxi;
    logic         busy;
    logic         fe;
    logic [13:0]  exp;
  } vec_t;

  function automatic logic [13:0] e(input logic v, input logic [3:0] m, input logic [2:0] i,
                                    input logic s, input logic tg, input logic rg,
                                    input logic td, input logic rd, input logic t);
    return {v, m, i, s, tg, rg, td, rd, t};
  endfunction

  function automatic vec_t mk(input logic r, input logic n, input logic tv, input logic [3:0] tm,
                              input logic [2:0] ti, input logic rv, input logic [3:0] rm,
                              input logic [2:0] ri, input logic b, input logic f,
                              input logic [13:0] x);
    vec_t t;
    t.rst = r; t.en = n; t.txv = tv; t.txm = tm; t.txi = ti;
    t.rxv = rv; t.rxm = rm; t.rxi = ri; t.busy = b; t.fe = f; t.exp = x;
    return t;
  endfunction

  function automatic logic [13:0] outs();
    return {sb_valid, sb_msg, sb_info, sb_src, tx_grant, rx_grant, tx_done, rx_done, tmo};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; en = t.en; txv = t.txv; txm = t.txm; txi = t.txi;
    rxv = t.rxv; rxm = t.rxm; rxi = t.rxi; busy = t.busy;
  endtask

  vec_t tbl[33];

  initial begin
    // TX only, busy high three cycles
    tbl[0]  = mk(0,1, 1,1,3'b001, 0,0,0, 0, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[1]  = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[2]  = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[3]  = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[4]  = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,1,3'b001,0, 0,0, 1,0,0));
    tbl[5]  = mk(0,1, 0,0,0,      0,0,0, 0, 0, e(0,1,3'b001,0, 0,0, 0,0,0));
    // Reset, then tie: TX first, RX next with a gap, tie again to TX
    tbl[6]  = mk(1,1, 0,0,0,      0,0,0, 0, 0, e(0,0,3'b000,0, 0,0, 0,0,0));
    tbl[7]  = mk(0,1, 1,1,3'b001, 1,2,3'b010, 0, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[8]  = mk(0,1, 0,0,0,      1,2,3'b010, 1, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[9]  = mk(0,1, 0,0,0,      1,2,3'b010, 0, 1, e(0,1,3'b001,0, 0,0, 1,0,0));
    tbl[10] = mk(0,1, 0,0,0,      1,2,3'b010, 0, 0, e(1,2,3'b010,1, 0,1, 0,0,0));
    tbl[11] = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,2,3'b010,1, 0,1, 0,0,0));
    tbl[12] = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,2,3'b010,1, 0,0, 0,1,0));
    tbl[13] = mk(0,1, 1,1,3'b001, 1,2,3'b010, 0, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[14] = mk(0,1, 0,0,0,      1,2,3'b010, 1, 0, e(1,1,3'b001,0, 1,0, 0,0,0));
    tbl[15] = mk(0,1, 0,0,0,      1,2,3'b010, 0, 1, e(0,1,3'b001,0, 0,0, 1,0,0));
    // Single-cycle busy pulse on an RX message
    tbl[16] = mk(0,1, 0,0,0,      1,2,3'b010, 0, 0, e(1,2,3'b010,1, 0,1, 0,0,0));
    tbl[17] = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,2,3'b010,1, 0,1, 0,0,0));
    tbl[18] = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,2,3'b010,1, 0,0, 0,1,0));
    // Busy already high at grant, falls while still in WAIT_BUSY
    tbl[19] = mk(0,1, 1,3,3'b100, 0,0,0, 1, 0, e(1,3,3'b100,0, 1,0, 0,0,0));
    tbl[20] = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,3,3'b100,0, 0,0, 1,0,0));
    // Enable drop in WAIT_DONE, then re-enable with the request still pending
    tbl[21] = mk(0,1, 0,0,0,      1,5,3'b010, 0, 0, e(1,5,3'b010,1, 0,1, 0,0,0));
    tbl[22] = mk(0,1, 0,0,0,      1,5,3'b010, 1, 0, e(1,5,3'b010,1, 0,1, 0,0,0));
    tbl[23] = mk(0,0, 0,0,0,      1,5,3'b010, 1, 0, e(0,5,3'b010,1, 0,0, 0,0,0));
    tbl[24] = mk(0,1, 0,0,0,      1,5,3'b010, 0, 1, e(1,5,3'b010,1, 0,1, 0,0,0));
    tbl[25] = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,5,3'b010,1, 0,1, 0,0,0));
    tbl[26] = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,5,3'b010,1, 0,0, 0,1,0));
    // Reset during WAIT_DONE restores TX tie priority
    tbl[27] = mk(0,1, 0,0,0,      1,6,3'b001, 0, 0, e(1,6,3'b001,1, 0,1, 0,0,0));
    tbl[28] = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,6,3'b001,1, 0,1, 0,0,0));
    tbl[29] = mk(1,1, 0,0,0,      0,0,0, 1, 0, e(0,0,3'b000,0, 0,0, 0,0,0));
    tbl[30] = mk(0,1, 1,7,3'b100, 1,8,3'b001, 0, 0, e(1,7,3'b100,0, 1,0, 0,0,0));
    tbl[31] = mk(0,1, 0,0,0,      0,0,0, 1, 0, e(1,7,3'b100,0, 1,0, 0,0,0));
    tbl[32] = mk(0,1, 0,0,0,      0,0,0, 0, 1, e(0,7,3'b100,0, 0,0, 1,0,0));

    rst = 1'b1; en = 1'b0; txv = 1'b0; rxv = 1'b0; busy = 1'b0;
    txm = '0; rxm = '0; txi = '0; rxi = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 14'd0);
    check("reset_fe", {13'd0, fe}, 14'd0);

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d_fe", i), {13'd0, fe}, {13'd0, tbl[i].fe});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d_out", i), outs(), tbl[i].exp);
    end

    // Watchdog: last owner is TX, so the tie goes to RX and busy never rises.
    rst = 1'b0; en = 1'b1; busy = 1'b0;
    txv = 1'b1; txm = 4'd9;  txi = 3'b001;
    rxv = 1'b1; rxm = 4'd10; rxi = 3'b100;
    @(posedge clk);
    @(negedge clk);
    check("to_grant", outs(), e(1,10,3'b100,1, 0,1, 0,0,0));
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < TO)
        check($sformatf("to_wait%0d", k), outs(), e(1,10,3'b100,1, 0,1, 0,0,0));
      else
        check("to_pulse", outs(), e(0,10,3'b100,1, 0,0, 0,0,1));
    end
    @(posedge clk);
    @(negedge clk);
    check("to_next_tie_tx", outs(), e(1,9,3'b001,0, 1,0, 0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phyretrain_sb_arbiter.md
# phyretrain_sb_arbiter

Shares the single sideband transmit channel between the TX-side and RX-side PHYRETRAIN message generators inside the LTSM. Each requester holds a message request until the arbiter grants it. The arbiter drives the request to the sideband wrapper and tracks the wrapper busy handshake to completion, then returns a one-cycle done pulse. Simultaneous requests alternate round-robin, and a watchdog aborts any transfer the wrapper never completes.

## Interface
Parameters:
- SB_MSG_WIDTH, 4, width of the decoded/encoded sideband message code
- TIMEOUT_CYCLES, 8000, maximum cycles from grant to busy falling edge before abort (≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, reset synchronous and active-high
- i_enable  in  1  PHYRETRAIN enable from LTSM; low = abort and hold IDLE
- i_tx_valid  in  1  TX requester has a message pending (level)
- i_tx_msg  in  SB_MSG_WIDTH  TX message code
- i_tx_info  in  3  TX msg info (001 TXSELFCAL, 010 SPEEDIDLE, 100 REPAIR)
- i_rx_valid  in  1  RX requester has a message pending (level)
- i_rx_msg  in  SB_MSG_WIDTH  RX message code
- i_rx_info  in  3  RX msg info
- i_sb_busy  in  1  wrapper busy while serializing a message
- o_sb_valid  out  1  message valid to wrapper
- o_sb_msg  out  SB_MSG_WIDTH  granted message code
- o_sb_info  out  3  granted msg info
- o_sb_src  out  1  0 = TX owns channel, 1 = RX owns channel
- o_tx_grant / o_rx_grant  out  1 each  requester currently owns channel
- o_tx_done / o_rx_done  out  1 each  one-cycle pulse: requester's message sent
- o_timeout  out  1  one-cycle pulse: transfer aborted by watchdog
- o_falling_edge_busy  out  1  combinational busy_d & ~i_sb_busy, broadcast

## Operation
- Registers: state, busy_d, last_grant (reset 1 = RX so TX wins first tie), watchdog counter of width $clog2(TIMEOUT_CYCLES+1).
- busy_d <= i_sb_busy every cycle. It is cleared by reset and is not affected by i_enable.
- States IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: grants nothing. With i_enable=1:
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester ≠ last_grant.
  - On grant: latch msg/info/src into output registers, set grant and o_sb_valid, clear the counter, and go to WAIT_BUSY.
- WAIT_BUSY: o_sb_valid held high.
  - i_sb_busy=1 → WAIT_DONE.
  - A falling edge seen here (busy pulse shorter than one state hop) counts as completion.
- WAIT_DONE: o_sb_valid held high until o_falling_edge_busy=1.
- Completion (falling edge in WAIT_BUSY or WAIT_DONE):
  - o_sb_valid←0, grant←0, done pulse to owner, last_grant←owner, → IDLE.
- Watchdog: counter increments each cycle in WAIT_BUSY/WAIT_DONE. At count TIMEOUT_CYCLES-1 without completion:
  - o_timeout pulse, o_sb_valid←0, grant←0, no done pulse, last_grant←owner, → IDLE.
- Requester drops valid while granted: the transfer continues on latched data and done still pulses. Inputs changing while granted are ignored.
- i_enable=0 in any state: next cycle state IDLE, o_sb_valid/grants/done/timeout←0, counter←0. No done pulse. last_grant is kept.
- Priority: i_rst > !i_enable > completion > timeout > normal transitions.
- o_sb_msg/o_sb_info/o_sb_src hold their last value after release; they are only meaningful with o_sb_valid.

## Timing
- Reset values: o_sb_valid, o_sb_msg, o_sb_info, o_sb_src, grants, dones, o_timeout = 0. o_falling_edge_busy = 0 after reset because busy_d = 0.
- Grant latency: valid sampled in IDLE at edge N → o_sb_valid, grant, msg registered at N+1.
- Completion: falling edge visible in cycle M → done pulse and o_sb_valid=0 from edge M+1 for one cycle, and state is IDLE.
- Back-to-back: the earliest next grant is visible at M+2, which gives a minimum one-cycle gap with o_sb_valid low between messages.
- Timeout: o_timeout is asserted exactly TIMEOUT_CYCLES cycles after o_sb_valid first rose, when no edge is seen.
- Done and timeout never assert in the same cycle.

## Test plan
- TX only: i_tx_valid=1, msg=1, info=001, then busy high 3 cycles → o_sb_valid 1 cycle after request, o_sb_msg=1, o_sb_src=0; o_tx_done pulses 1 cycle after busy falls; o_sb_valid=0 simultaneously.
- Tie after reset: both valid (TX msg=1, RX msg=2) → TX granted first; after its completion, RX granted with a 1-cycle valid-low gap; o_sb_src=1. Repeat the tie → TX again.
- Short busy: busy high for 1 cycle while in WAIT_BUSY → completion still detected, o_rx_done/o_tx_done pulses once.
- Timeout with TIMEOUT_CYCLES=16: grant, busy never rises → o_timeout pulses 16 cycles after o_sb_valid rose, no done, state returns to IDLE, next tie goes to the other requester.
- Abort: i_enable→0 in WAIT_DONE → next cycle o_sb_valid=0, grants 0, no done/timeout. Re-enable with pending request → fresh grant after 1 cycle.
- Reset mid-transfer: i_rst=1 for 1 cycle during WAIT_DONE → all outputs 0 at next edge; last_grant back to RX, so a tie then grants TX.
